// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave over 2**ADDR_WIDTH bytes: NONSEQ wait states, byte/half/word writes, two-cycle ERROR.
// Define AHB_SRAM_WPROT_EN to add WPROT_LOCK, which write-protects the upper quarter of the region.
module ahb_sram_slave #(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [1:0]            HTRANS,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
`ifdef AHB_SRAM_WPROT_EN
    input  logic                  WPROT_LOCK,
`endif
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA
);
    localparam int WORDS = (2 ** ADDR_WIDTH) / 4;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [2:0]              size_q;
    logic [1:0]              trans_q;
    logic                    wr_pend;
    logic [2:0]              wait_cnt;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [DATA_WIDTH-1:0]   mem [WORDS];
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [3:0]              be;
    logic                    cap;
    logic                    legal;
    logic                    wprot_hit;
    logic                    unused_ok;

    assign cap = HSEL && HREADY && HTRANS[1];

`ifdef AHB_SRAM_WPROT_EN
    assign wprot_hit = WPROT_LOCK && HWRITE && (HADDR[ADDR_WIDTH-1:ADDR_WIDTH-2] == 2'b11);
`else
    assign wprot_hit = 1'b0;
`endif

    assign legal = (HSIZE <= 3'b010)
                && !(HSIZE == 3'b001 && HADDR[0])
                && !(HSIZE == 3'b010 && HADDR[1:0] != 2'b00)
                && !wprot_hit;

    assign rd_word = mem[addr_q[ADDR_WIDTH-1:2]];

    // Read data is live only in a read DATA cycle; otherwise the last read word is held.
    assign HRDATA = (state == S_DATA && !wr_pend) ? rd_word : rdata_q;

    always_comb begin
        be = 4'b0000;
        case (size_q)
            3'b000:  be[addr_q[1:0]] = 1'b1;
            3'b001:  be = addr_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // Write lands on the edge ending DATA, so the next beat reads the new word directly.
    always_ff @(posedge HCLK) begin
        if (!HRESET && state == S_DATA && wr_pend) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[addr_q[ADDR_WIDTH-1:2]][8*b +: 8] <= HWDATA[8*b +: 8];
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state     <= S_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            wait_cnt  <= 3'd0;
            wr_pend   <= 1'b0;
            addr_q    <= '0;
            size_q    <= 3'd0;
            trans_q   <= 2'd0;
            rdata_q   <= '0;
        end else begin
            if (state == S_DATA && !wr_pend) rdata_q <= rd_word;
            case (state)
                S_WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        state     <= S_DATA;
                        HREADYOUT <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                S_ERR1: begin
                    state     <= S_ERR2;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b1;
                end
                default: begin
                    // IDLE, DATA and ERR2 all end with HREADYOUT=1 and may take a new address phase.
                    if (cap) begin
                        addr_q  <= HADDR[ADDR_WIDTH-1:0];
                        size_q  <= HSIZE;
                        trans_q <= HTRANS;
                        if (!legal) begin
                            state     <= S_ERR1;
                            HREADYOUT <= 1'b0;
                            HRESP     <= 1'b1;
                            wr_pend   <= 1'b0;
                        end else if (HTRANS == 2'b10 && WAIT_STATES > 0) begin
                            state     <= S_WAIT;
                            wait_cnt  <= 3'(WAIT_STATES - 1);
                            HREADYOUT <= 1'b0;
                            HRESP     <= 1'b0;
                            wr_pend   <= HWRITE;
                        end else begin
                            state     <= S_DATA;
                            HREADYOUT <= 1'b1;
                            HRESP     <= 1'b0;
                            wr_pend   <= HWRITE;
                        end
                    end else begin
                        state     <= S_IDLE;
                        HREADYOUT <= 1'b1;
                        HRESP     <= 1'b0;
                        wr_pend   <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign unused_ok = &{1'b0, HBURST, HADDR[31:ADDR_WIDTH], trans_q};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave (WAIT_STATES=2): pipelined AHB beats, read expectations via a queue.
`timescale 1ns/1ps
module tb_ahb_sram_slave;
    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsel;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
    logic        wlock;

    int errors = 0;
    int checks = 0;

    logic [31:0] model [256];
    logic [31:0] exp_q [$];
    logic [31:0] last_rd;

    logic        p_vld, p_rd, p_err;
    int          p_waits;
    logic [31:0] p_wdata;

    always #5 clk = ~clk;
    assign hready = hreadyout;

    ahb_sram_slave #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_STATES(WS)) dut (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HWDATA(hwdata), .HREADY(hready),
`ifdef AHB_SRAM_WPROT_EN
        .WPROT_LOCK(wlock),
`endif
        .HREADYOUT(hreadyout), .HRESP(hresp), .HRDATA(hrdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic is_legal(input logic wr, input logic [31:0] a, input logic [2:0] sz);
        logic ok;
        ok = (sz <= 3'd2) && !(sz == 3'd1 && a[0]) && !(sz == 3'd2 && a[1:0] != 2'b00);
`ifdef AHB_SRAM_WPROT_EN
        if (wlock && wr && a[9:8] == 2'b11) ok = 1'b0;
`else
        if (wr && 1'b0) ok = 1'b0;
`endif
        return ok;
    endfunction

    // Present one address phase, finish the previous data phase, then record what this beat must do.
    task automatic beat(input logic sel, input logic wr, input logic [31:0] a,
                        input logic [2:0] sz, input logic [1:0] tr, input logic [31:0] wd);
        int          w;
        logic        xfer, lg;
        logic [3:0]  lanes;
        logic [31:0] exp;
        hsel = sel; haddr = a; hwrite = wr; hsize = sz; htrans = tr; hwdata = p_wdata;
        if (p_vld) begin
            w = 0;
            while (hreadyout !== 1'b1 && w < 20) begin
                chk("wait_resp", {31'b0, hresp}, {31'b0, p_err});
                @(posedge clk); @(negedge clk);
                w++;
            end
            chk("wait_count", 32'(w), 32'(p_waits));
            chk("resp", {31'b0, hresp}, {31'b0, p_err});
            if (p_rd) begin
                exp = exp_q.pop_front();
                chk("rdata", hrdata, exp);
                last_rd = exp;
            end else begin
                chk("rdata_hold", hrdata, last_rd);
            end
        end
        @(posedge clk); @(negedge clk);
        xfer    = sel && tr[1];
        lg      = is_legal(wr, a, sz);
        p_vld   = 1'b1;
        p_err   = xfer && !lg;
        p_rd    = xfer && lg && !wr;
        p_waits = !xfer ? 0 : (!lg ? 1 : (tr == 2'b10 ? WS : 0));
        p_wdata = wd;
        if (xfer && lg && wr) begin
            case (sz)
                3'd0:    lanes = 4'b0001 << a[1:0];
                3'd1:    lanes = a[1] ? 4'b1100 : 4'b0011;
                default: lanes = 4'b1111;
            endcase
            for (int b = 0; b < 4; b++)
                if (lanes[b]) model[a[9:2]][8*b +: 8] = wd[8*b +: 8];
        end
        if (p_rd) exp_q.push_back(model[a[9:2]]);
    endtask

    localparam logic [1:0] IDL = 2'b00, BSY = 2'b01, NSQ = 2'b10, SEQ = 2'b11;

    initial begin
        rst = 1'b1; hsel = 1'b0; haddr = '0; hwrite = 1'b0; hsize = 3'd2;
        hburst = 3'd0; htrans = IDL; hwdata = '0; wlock = 1'b0;
        p_vld = 1'b0; p_rd = 1'b0; p_err = 1'b0; p_waits = 0; p_wdata = '0; last_rd = '0;
        @(negedge clk);
        chk("rst_readyout", {31'b0, hreadyout}, 32'd1);
        chk("rst_resp", {31'b0, hresp}, 32'd0);
        chk("rst_rdata", hrdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Word write then back-to-back SEQ read of the same address
        beat(1, 1, 32'h010, 3'd2, NSQ, 32'hDEADBEEF);
        beat(1, 0, 32'h010, 3'd2, SEQ, 32'h0);
        beat(1, 0, 32'h010, 3'd2, IDL, 32'h0);
        // Burst of writes, then NONSEQ read with waits followed by zero-wait SEQ beats
        beat(1, 1, 32'h020, 3'd2, NSQ, 32'hA0A0A0A0);
        beat(1, 1, 32'h024, 3'd2, SEQ, 32'hB1B1B1B1);
        beat(1, 1, 32'h028, 3'd2, SEQ, 32'hC2C2C2C2);
        beat(1, 0, 32'h020, 3'd2, NSQ, 32'h0);
        beat(1, 0, 32'h024, 3'd2, SEQ, 32'h0);
        beat(1, 0, 32'h028, 3'd2, SEQ, 32'h0);
        beat(1, 0, 32'h000, 3'd2, BSY, 32'h0);
        // Byte and halfword lanes
        beat(1, 1, 32'h030, 3'd2, NSQ, 32'h11223344);
        beat(1, 1, 32'h031, 3'd0, SEQ, 32'h0000AA00);
        beat(1, 0, 32'h030, 3'd2, SEQ, 32'h0);
        beat(1, 1, 32'h032, 3'd1, SEQ, 32'hBEEF0000);
        beat(1, 0, 32'h030, 3'd2, SEQ, 32'h0);
        beat(1, 1, 32'h034, 3'd1, SEQ, 32'h00005566);
        beat(1, 0, 32'h034, 3'd2, SEQ, 32'h0);
        // Illegal accesses, including back-to-back from ERR2, then a legal read
        beat(1, 1, 32'h000, 3'd2, NSQ, 32'hCAFEF00D);
        beat(0, 0, 32'h000, 3'd2, IDL, 32'h0);
        beat(1, 1, 32'h002, 3'd2, NSQ, 32'h12121212);
        beat(1, 0, 32'h004, 3'd3, NSQ, 32'h0);
        beat(1, 1, 32'h001, 3'd1, NSQ, 32'h34343434);
        beat(1, 0, 32'h000, 3'd2, NSQ, 32'h0);
        // HSEL dropped while the read above is still in its wait cycles
        beat(0, 0, 32'h000, 3'd2, NSQ, 32'h0);
        // Aliasing of upper address bits
        beat(1, 1, 32'h410, 3'd2, NSQ, 32'h12345678);
        beat(1, 0, 32'h010, 3'd2, SEQ, 32'h0);
        // Reset during the wait cycles of a write
        beat(1, 1, 32'h040, 3'd2, NSQ, 32'h40404040);
        beat(0, 0, 32'h000, 3'd2, IDL, 32'h0);
        hsel = 1'b1; haddr = 32'h040; hwrite = 1'b1; hsize = 3'd2; htrans = NSQ;
        @(posedge clk); @(negedge clk);
        hwdata = 32'h0BAD0BAD;
        chk("wait_before_rst", {31'b0, hreadyout}, 32'd0);
        rst = 1'b1;
        #1;
        chk("arst_readyout", {31'b0, hreadyout}, 32'd1);
        chk("arst_resp", {31'b0, hresp}, 32'd0);
        chk("arst_rdata", hrdata, 32'd0);
        hsel = 1'b0; htrans = IDL;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        p_vld = 1'b0; p_wdata = '0; last_rd = '0;
        beat(1, 0, 32'h040, 3'd2, NSQ, 32'h0);
        beat(1, 0, 32'h010, 3'd2, SEQ, 32'h0);
`ifdef AHB_SRAM_WPROT_EN
        // Write protection of the upper quarter
        wlock = 1'b0;
        beat(1, 1, 32'h300, 3'd2, NSQ, 32'h11111111);
        beat(0, 0, 32'h000, 3'd2, IDL, 32'h0);
        wlock = 1'b1;
        beat(1, 1, 32'h300, 3'd0, NSQ, 32'h0000005A);
        beat(1, 0, 32'h300, 3'd2, NSQ, 32'h0);
        beat(0, 0, 32'h000, 3'd2, IDL, 32'h0);
        wlock = 1'b0;
        beat(1, 1, 32'h300, 3'd0, NSQ, 32'h0000005A);
        beat(1, 0, 32'h300, 3'd2, SEQ, 32'h0);
`endif
        beat(0, 0, 32'h000, 3'd2, IDL, 32'h0);
        beat(0, 0, 32'h000, 3'd2, IDL, 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
